// File: rtl/param_coeff_loader.sv
// ============================================================================
// Module      : param_coeff_loader
// Description : Walks NUM_COEFFS coefficients from an external store into the
//               FIR datapath using a load_coeff/modwait handshake. Optional
//               handshake timeout is enabled by COEFF_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module param_coeff_loader #(
    parameter int NUM_COEFFS     = 4,
    parameter int COEFF_W        = 16,
    parameter int IDX_W          = $clog2(NUM_COEFFS),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_coefficient_set,
    input  logic               modwait,
    input  logic [COEFF_W-1:0] coeff_rdata,
    output logic [IDX_W-1:0]   coeff_addr,
    output logic               load_coeff,
    output logic [IDX_W-1:0]   coefficient_num,
    output logic [COEFF_W-1:0] coeff_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FETCH   = 3'd1;
    localparam logic [2:0] c_ISSUE   = 3'd2;
    localparam logic [2:0] c_WAIT_LO = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_COEFFS - 1);

    if (NUM_COEFFS < 2) begin : g_chk_num_coeffs
        $error("param_coeff_loader: NUM_COEFFS must be at least 2");
    end

    if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
        $error("param_coeff_loader: TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_index;
    logic               r_pending;
    logic [IDX_W-1:0]   r_coeff_num;
    logic [COEFF_W-1:0] r_coeff_data;
    logic               w_timeout;
    logic               w_start;
    logic               w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (new_coefficient_set) begin
                    w_state_nxt = c_FETCH;
                end
            end
            c_FETCH: begin
                w_state_nxt = c_ISSUE;
            end
            c_ISSUE: begin
                if (modwait) begin
                    w_state_nxt = c_WAIT_LO;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT_LO: begin
                if (!modwait) begin
                    w_state_nxt = (r_index == c_LAST_IDX) ? c_DONE : c_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DONE: begin
                // A request seen in the DONE cycle itself also restarts, so
                // it is never lost between pending capture and IDLE.
                w_state_nxt = (r_pending || new_coefficient_set) ? c_FETCH : c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign w_start = ((r_state == c_IDLE) || (r_state == c_DONE)) &&
                     (w_state_nxt == c_FETCH);
    assign w_abort = w_timeout && (w_state_nxt == c_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_index      <= '0;
            r_pending    <= 1'b0;
            r_coeff_num  <= '0;
            r_coeff_data <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_start || w_abort) begin
                r_pending <= 1'b0;
            end else if (new_coefficient_set && (r_state != c_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (w_start) begin
                r_index <= '0;
            end else if ((r_state == c_WAIT_LO) && !modwait && (r_index != c_LAST_IDX)) begin
                r_index <= r_index + IDX_W'(1);
            end

            if (r_state == c_FETCH) begin
                r_coeff_data <= coeff_rdata;
                r_coeff_num  <= r_index;
            end
        end
    end

`ifdef COEFF_LOADER_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;

    // Counter restarts on every state change, so it measures dwell time in
    // the current handshake phase only.
    always_ff @(posedge clk) begin
        if (reset || (r_state != w_state_nxt)) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_ISSUE) || (r_state == c_WAIT_LO)) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign w_timeout = ((r_state == c_ISSUE) || (r_state == c_WAIT_LO)) &&
                       (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if ((r_state == c_IDLE) && new_coefficient_set) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign coeff_addr      = r_index;
    assign coefficient_num = r_coeff_num;
    assign coeff_data      = r_coeff_data;
    assign load_coeff      = (r_state == c_ISSUE);
    assign busy            = (r_state != c_IDLE);
    assign done            = (r_state == c_DONE);

endmodule

`default_nettype wire
